// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - state encoding, requester IDs and wait-counter width for memory_arbiter
package memory_arbiter_pkg;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Requester identifiers, also the encoding of the last-grant flag
  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  // Wait-state counter sized for the largest supported WAIT_STATES value
  localparam int WAIT_STATES_MAX = 15;
  localparam int WAIT_CNT_W      = $clog2(WAIT_STATES_MAX + 1);

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - CPU, loader and memory-side signals of memory_arbiter
interface memory_arbiter_if #(
  parameter int DATAWIDTH_BUS     = 32,
  parameter int DATAWIDTH_MEMADDR = 12
);

  logic                         MEMORY_ARBITER_CpuRD_In;
  logic                         MEMORY_ARBITER_CpuWR_In;
  logic [DATAWIDTH_BUS-1:0]     MEMORY_ARBITER_CpuAddress_InBus;
  logic [DATAWIDTH_BUS-1:0]     MEMORY_ARBITER_CpuData_InBus;
  logic                         MEMORY_ARBITER_CpuAck_Out;
  logic                         MEMORY_ARBITER_LoaderReq_In;
  logic                         MEMORY_ARBITER_LoaderWE_In;
  logic [DATAWIDTH_MEMADDR-1:0] MEMORY_ARBITER_LoaderAddress_InBus;
  logic [DATAWIDTH_BUS-1:0]     MEMORY_ARBITER_LoaderData_InBus;
  logic                         MEMORY_ARBITER_LoaderAck_Out;
  logic [DATAWIDTH_BUS-1:0]     MEMORY_ARBITER_ReadData_OutBus;
  logic [DATAWIDTH_MEMADDR-1:0] MEMORY_ARBITER_MemAddress_OutBus;
  logic [DATAWIDTH_BUS-1:0]     MEMORY_ARBITER_MemData_OutBus;
  logic                         MEMORY_ARBITER_MemRE_Out;
  logic                         MEMORY_ARBITER_MemWE_Out;
  logic [DATAWIDTH_BUS-1:0]     MEMORY_ARBITER_MemData_InBus;

  // Requesters and the memory model drive requests and read data
  modport master (
    output MEMORY_ARBITER_CpuRD_In, MEMORY_ARBITER_CpuWR_In,
    output MEMORY_ARBITER_CpuAddress_InBus, MEMORY_ARBITER_CpuData_InBus,
    output MEMORY_ARBITER_LoaderReq_In, MEMORY_ARBITER_LoaderWE_In,
    output MEMORY_ARBITER_LoaderAddress_InBus, MEMORY_ARBITER_LoaderData_InBus,
    output MEMORY_ARBITER_MemData_InBus,
    input  MEMORY_ARBITER_CpuAck_Out, MEMORY_ARBITER_LoaderAck_Out,
    input  MEMORY_ARBITER_ReadData_OutBus, MEMORY_ARBITER_MemAddress_OutBus,
    input  MEMORY_ARBITER_MemData_OutBus, MEMORY_ARBITER_MemRE_Out,
    input  MEMORY_ARBITER_MemWE_Out
  );

  // The arbiter itself
  modport slave (
    input  MEMORY_ARBITER_CpuRD_In, MEMORY_ARBITER_CpuWR_In,
    input  MEMORY_ARBITER_CpuAddress_InBus, MEMORY_ARBITER_CpuData_InBus,
    input  MEMORY_ARBITER_LoaderReq_In, MEMORY_ARBITER_LoaderWE_In,
    input  MEMORY_ARBITER_LoaderAddress_InBus, MEMORY_ARBITER_LoaderData_InBus,
    input  MEMORY_ARBITER_MemData_InBus,
    output MEMORY_ARBITER_CpuAck_Out, MEMORY_ARBITER_LoaderAck_Out,
    output MEMORY_ARBITER_ReadData_OutBus, MEMORY_ARBITER_MemAddress_OutBus,
    output MEMORY_ARBITER_MemData_OutBus, MEMORY_ARBITER_MemRE_Out,
    output MEMORY_ARBITER_MemWE_Out
  );

endinterface

// File: rtl/memory_arbiter_grant.sv
// rtl/memory_arbiter_grant.sv - winner selection and owner/last-grant register (MEMORY_ARBITER_ROUND_ROBIN_EN selects round robin)
module memory_arbiter_grant
  import memory_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic cpu_req_i,
  input  logic loader_req_i,
  input  logic grant_i,
  output logic winner_o,
  output logic owner_o
);

  // Owner of the transaction in flight; it holds the previous winner
  // between grants, so in round-robin builds it is also the last-grant flag.
  logic owner_q, owner_d;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  // On a tie, hand the memory to whoever was not served last
  always_comb begin
    if (cpu_req_i && loader_req_i) begin
      winner_o = (owner_q == REQ_LOADER) ? REQ_CPU : REQ_LOADER;
    end else begin
      winner_o = cpu_req_i ? REQ_CPU : REQ_LOADER;
    end
  end
`else
  // Fixed priority: the loader only wins when the CPU is not asking
  always_comb begin
    winner_o = (cpu_req_i || !loader_req_i) ? REQ_CPU : REQ_LOADER;
  end
`endif

  // Capture the winner at each grant
  always_comb begin
    owner_d = grant_i ? winner_o : owner_q;
  end

  // Owner register; LOADER at reset so the CPU wins the first tie
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= REQ_LOADER;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - CPU/loader arbiter for the single-port main memory (MEMORY_ARBITER_ROUND_ROBIN_EN enables round robin)
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATAWIDTH_BUS     = 32,
  parameter int DATAWIDTH_MEMADDR = 12,
  parameter int WAIT_STATES       = 2
) (
  input logic             MEMORY_ARBITER_CLOCK_50,
  input logic             MEMORY_ARBITER_ResetInHigh_In,
  memory_arbiter_if.slave bus
);

  logic [1:0]                   state_q, state_d;
  wait_cnt_t                    wait_q, wait_d;
  logic [DATAWIDTH_MEMADDR-1:0] addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0]     wdata_q, wdata_d;
  logic [DATAWIDTH_BUS-1:0]     rdata_q, rdata_d;
  logic                         re_q, re_d;
  logic                         we_q, we_d;
  logic                         cpu_ack_q, cpu_ack_d;
  logic                         loader_ack_q, loader_ack_d;

  logic                         cpu_req;
  logic                         loader_req;
  logic                         grant;
  logic                         winner;
  logic                         owner;
  logic [DATAWIDTH_MEMADDR-1:0] cpu_word_addr;
  logic                         unused_cpu_addr_bits;

  assign cpu_req    = bus.MEMORY_ARBITER_CpuRD_In | bus.MEMORY_ARBITER_CpuWR_In;
  assign loader_req = bus.MEMORY_ARBITER_LoaderReq_In;
  assign grant      = (state_q == ST_IDLE) && (cpu_req || loader_req);

  // CPU issues byte addresses; memory is word addressed
  assign cpu_word_addr = bus.MEMORY_ARBITER_CpuAddress_InBus[DATAWIDTH_MEMADDR+1:2];
  assign unused_cpu_addr_bits =
    ^{bus.MEMORY_ARBITER_CpuAddress_InBus[DATAWIDTH_BUS-1:DATAWIDTH_MEMADDR+2],
      bus.MEMORY_ARBITER_CpuAddress_InBus[1:0]};

  memory_arbiter_grant u_grant (
    .clk_i        (MEMORY_ARBITER_CLOCK_50),
    .rst_i        (MEMORY_ARBITER_ResetInHigh_In),
    .cpu_req_i    (cpu_req),
    .loader_req_i (loader_req),
    .grant_i      (grant),
    .winner_o     (winner),
    .owner_o      (owner)
  );

  // Sequencing IDLE -> ACCESS (strobes, wait states) -> DONE (ack) -> IDLE;
  // the strobe registers double as the latched direction of the access.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    re_d         = re_q;
    we_d         = we_q;
    cpu_ack_d    = 1'b0;
    loader_ack_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_ACCESS;
          wait_d  = wait_cnt_t'(WAIT_STATES);
          if (winner == REQ_CPU) begin
            addr_d  = cpu_word_addr;
            wdata_d = bus.MEMORY_ARBITER_CpuData_InBus;
            we_d    = bus.MEMORY_ARBITER_CpuWR_In;
            re_d    = ~bus.MEMORY_ARBITER_CpuWR_In;
          end else begin
            addr_d  = bus.MEMORY_ARBITER_LoaderAddress_InBus;
            wdata_d = bus.MEMORY_ARBITER_LoaderData_InBus;
            we_d    = bus.MEMORY_ARBITER_LoaderWE_In;
            re_d    = ~bus.MEMORY_ARBITER_LoaderWE_In;
          end
        end
      end
      ST_ACCESS: begin
        if (wait_q == '0) begin
          state_d = ST_DONE;
          re_d    = 1'b0;
          we_d    = 1'b0;
          if (re_q) begin
            rdata_d = bus.MEMORY_ARBITER_MemData_InBus;
          end
          if (owner == REQ_CPU) begin
            cpu_ack_d = 1'b1;
          end else begin
            loader_ack_d = 1'b1;
          end
        end else begin
          wait_d = wait_q - wait_cnt_t'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight
  always_ff @(posedge MEMORY_ARBITER_CLOCK_50) begin
    if (MEMORY_ARBITER_ResetInHigh_In) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      cpu_ack_q    <= 1'b0;
      loader_ack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      re_q         <= re_d;
      we_q         <= we_d;
      cpu_ack_q    <= cpu_ack_d;
      loader_ack_q <= loader_ack_d;
    end
  end

  assign bus.MEMORY_ARBITER_MemAddress_OutBus = addr_q;
  assign bus.MEMORY_ARBITER_MemData_OutBus    = wdata_q;
  assign bus.MEMORY_ARBITER_MemRE_Out         = re_q;
  assign bus.MEMORY_ARBITER_MemWE_Out         = we_q;
  assign bus.MEMORY_ARBITER_ReadData_OutBus   = rdata_q;
  assign bus.MEMORY_ARBITER_CpuAck_Out        = cpu_ack_q;
  assign bus.MEMORY_ARBITER_LoaderAck_Out     = loader_ack_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter (honours MEMORY_ARBITER_ROUND_ROBIN_EN)
module tb_memory_arbiter;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  memory_arbiter_if #(.DATAWIDTH_BUS(DW), .DATAWIDTH_MEMADDR(AW)) arb_bus ();

  memory_arbiter #(
    .DATAWIDTH_BUS     (DW),
    .DATAWIDTH_MEMADDR (AW),
    .WAIT_STATES       (WS)
  ) dut (
    .MEMORY_ARBITER_CLOCK_50       (clk),
    .MEMORY_ARBITER_ResetInHigh_In (rst),
    .bus                           (arb_bus)
  );

  // Environment memory answering the arbiter, and the reference copy
  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  assign arb_bus.MEMORY_ARBITER_MemData_InBus = mem[arb_bus.MEMORY_ARBITER_MemAddress_OutBus];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Requester agents
  bit          cpu_pend, cpu_hold, cpu_granted;
  int          cpu_kind;
  logic [31:0] cpu_addr, cpu_data;
  bit          ld_pend, ld_hold, ld_granted, ld_we;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;
  bit          rst_drv = 1'b1;
  bit          scramble_en;

  // Transaction-level reference model
  bit          m_active;
  int          m_start;
  bit          m_owner;
  bit          m_write;
  int          m_addr;
  logic [31:0] m_data;
  logic [31:0] m_rdata = '0;
  bit          m_last = 1'b1;

  // Observations
  int          re_cnt, we_cnt, cack_cnt, lack_cnt, ack_n;
  int          last_cack_cyc, last_lack_cyc;
  logic [7:0]  ack_seq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    if (scramble_en && cpu_granted) begin
      cpu_addr = $urandom;
      cpu_data = $urandom;
    end
    if (scramble_en && ld_granted) begin
      ld_addr = 12'($urandom);
      ld_data = $urandom;
    end
    rst = rst_drv;
    arb_bus.MEMORY_ARBITER_CpuRD_In            = cpu_pend && (cpu_kind != 1);
    arb_bus.MEMORY_ARBITER_CpuWR_In            = cpu_pend && (cpu_kind != 0);
    arb_bus.MEMORY_ARBITER_CpuAddress_InBus    = cpu_addr;
    arb_bus.MEMORY_ARBITER_CpuData_InBus       = cpu_data;
    arb_bus.MEMORY_ARBITER_LoaderReq_In        = ld_pend;
    arb_bus.MEMORY_ARBITER_LoaderWE_In         = ld_we;
    arb_bus.MEMORY_ARBITER_LoaderAddress_InBus = ld_addr;
    arb_bus.MEMORY_ARBITER_LoaderData_InBus    = ld_data;
  endtask

  task automatic model_and_check();
    bit          in_acc, ack_now, pick_ld;
    logic        re, we, cack, lack;
    logic [11:0] a_out;
    logic [31:0] d_out;
    re    = arb_bus.MEMORY_ARBITER_MemRE_Out;
    we    = arb_bus.MEMORY_ARBITER_MemWE_Out;
    cack  = arb_bus.MEMORY_ARBITER_CpuAck_Out;
    lack  = arb_bus.MEMORY_ARBITER_LoaderAck_Out;
    a_out = arb_bus.MEMORY_ARBITER_MemAddress_OutBus;
    d_out = arb_bus.MEMORY_ARBITER_MemData_OutBus;

    if (m_active && cyc >= m_start + WS + 3) m_active = 1'b0;
    in_acc  = m_active && (cyc >= m_start + 1) && (cyc <= m_start + 1 + WS);
    ack_now = m_active && (cyc == m_start + 2 + WS);
    if (ack_now) begin
      if (m_write) ref_mem[m_addr] = m_data;
      else         m_rdata = ref_mem[m_addr];
    end

    check("mem_re", 32'(re), 32'(in_acc && !m_write));
    check("mem_we", 32'(we), 32'(in_acc && m_write));
    check("cpu_ack", 32'(cack), 32'(ack_now && !m_owner));
    check("loader_ack", 32'(lack), 32'(ack_now && m_owner));
    check("read_data", arb_bus.MEMORY_ARBITER_ReadData_OutBus, m_rdata);
    if (in_acc) check("mem_addr", 32'(a_out), 32'(m_addr));
    if (in_acc && m_write) check("mem_wdata", d_out, m_data);

    if (re === 1'b1) re_cnt++;
    if (we === 1'b1) begin
      we_cnt++;
      mem[a_out] = d_out;
    end

    if (rst_drv) begin
      if (m_active && m_write && cyc >= m_start + 1) ref_mem[m_addr] = m_data;
      m_active    = 1'b0;
      m_rdata     = '0;
      m_last      = 1'b1;
      cpu_granted = 1'b0;
      ld_granted  = 1'b0;
    end else if (!m_active && (cpu_pend || ld_pend)) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      if (cpu_pend && ld_pend) pick_ld = !m_last;
      else                     pick_ld = !cpu_pend;
`else
      pick_ld = !cpu_pend;
`endif
      m_active = 1'b1;
      m_start  = cyc;
      m_owner  = pick_ld;
      m_last   = pick_ld;
      if (pick_ld) begin
        m_write    = ld_we;
        m_addr     = int'(ld_addr);
        m_data     = ld_data;
        ld_granted = 1'b1;
      end else begin
        m_write     = (cpu_kind != 0);
        m_addr      = int'((cpu_addr >> 2) % 32'd4096);
        m_data      = cpu_data;
        cpu_granted = 1'b1;
      end
    end

    if (cack === 1'b1) begin
      cack_cnt++;
      ack_n++;
      last_cack_cyc = cyc;
      ack_seq       = {ack_seq[6:0], 1'b0};
      cpu_granted   = 1'b0;
      if (!cpu_hold) cpu_pend = 1'b0;
    end
    if (lack === 1'b1) begin
      lack_cnt++;
      ack_n++;
      last_lack_cyc = cyc;
      ack_seq       = {ack_seq[6:0], 1'b1};
      ld_granted    = 1'b0;
      if (!ld_hold) ld_pend = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    model_and_check();
  endtask

  task automatic run_until_acks(input string tag, input int n_acks, input int limit);
    int n0;
    int k;
    n0 = ack_n;
    k  = 0;
    while ((ack_n - n0) < n_acks && k < limit) begin
      step();
      k++;
    end
    check(tag, 32'(ack_n - n0), 32'(n_acks));
  endtask

  task automatic clear_counts();
    re_cnt = 0; we_cnt = 0; cack_cnt = 0; lack_cnt = 0; ack_seq = '0;
  endtask

  initial begin
    int t0;
    int t1;
    arb_bus.MEMORY_ARBITER_CpuRD_In     = 1'b0;
    arb_bus.MEMORY_ARBITER_CpuWR_In     = 1'b0;
    arb_bus.MEMORY_ARBITER_LoaderReq_In = 1'b0;
    arb_bus.MEMORY_ARBITER_LoaderWE_In  = 1'b0;
    cpu_addr = '0; cpu_data = '0; ld_addr = '0; ld_data = '0; cpu_kind = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    // Reset state
    repeat (3) step();
    rst_drv = 1'b0;
    step();
    check("rst_mem_addr", 32'(arb_bus.MEMORY_ARBITER_MemAddress_OutBus), 32'h0);
    check("rst_mem_data", arb_bus.MEMORY_ARBITER_MemData_OutBus, 32'h0);
    check("rst_read_data", arb_bus.MEMORY_ARBITER_ReadData_OutBus, 32'h0);

    // CPU read of byte 0x10 (word 4)
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    clear_counts();
    cpu_kind = 0; cpu_addr = 32'h0000_0010; cpu_pend = 1'b1;
    t0 = cyc + 1;
    run_until_acks("rd_ack", 1, 20);
    check("rd_latency", 32'(last_cack_cyc - t0), 32'(WS + 2));
    check("rd_re_cycles", 32'(re_cnt), 32'(WS + 1));
    check("rd_we_cycles", 32'(we_cnt), 32'h0);
    check("rd_data", arb_bus.MEMORY_ARBITER_ReadData_OutBus, 32'hDEADBEEF);
    step(); step();

    // RD and WR together: a write
    clear_counts();
    cpu_kind = 2; cpu_addr = 32'h0000_0008; cpu_data = 32'h12345678; cpu_pend = 1'b1;
    run_until_acks("rdwr_ack", 1, 20);
    check("rdwr_we_cycles", 32'(we_cnt), 32'(WS + 1));
    check("rdwr_re_cycles", 32'(re_cnt), 32'h0);
    check("rdwr_mem", mem[2], 32'h12345678);
    check("rdwr_read_data", arb_bus.MEMORY_ARBITER_ReadData_OutBus, 32'hDEADBEEF);
    step();

    // Simultaneous held requests after reset
    rst_drv = 1'b1; step(); rst_drv = 1'b0;
    clear_counts();
    cpu_kind = 0; cpu_addr = 32'h0000_0030; cpu_hold = 1'b1; cpu_pend = 1'b1;
    ld_we = 1'b0; ld_addr = 12'h005; ld_hold = 1'b1; ld_pend = 1'b1;
    run_until_acks("tie_acks", 3, 40);
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    check("tie_order", 32'(ack_seq[2:0]), 32'h2);
`else
    check("tie_order", 32'(ack_seq[2:0]), 32'h0);
    check("tie_loader_starved", 32'(lack_cnt), 32'h0);
`endif
    cpu_hold = 1'b0; cpu_pend = 1'b0; ld_hold = 1'b0;
    run_until_acks("tie_loader_served", 1, 20);
    step();

    // Loader write then read-back of word 0x7FF
    clear_counts();
    ld_we = 1'b1; ld_addr = 12'h7FF; ld_data = 32'hA5A5A5A5; ld_pend = 1'b1;
    run_until_acks("ld_wr_ack", 1, 20);
    ld_we = 1'b0; ld_data = 32'h0; ld_pend = 1'b1;
    run_until_acks("ld_rd_ack", 1, 20);
    check("ld_ack_count", 32'(lack_cnt), 32'h2);
    check("ld_cpu_ack_quiet", 32'(cack_cnt), 32'h0);
    check("ld_read_data", arb_bus.MEMORY_ARBITER_ReadData_OutBus, 32'hA5A5A5A5);
    step();

    // Reset during the second ACCESS cycle, request held through it
    clear_counts();
    cpu_kind = 0; cpu_addr = 32'h0000_0020; cpu_pend = 1'b1;
    t0 = cyc + 1;
    step(); step();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    step();
    t1 = t0 + 3;
    check("abort_re", 32'(arb_bus.MEMORY_ARBITER_MemRE_Out), 32'h0);
    check("abort_we", 32'(arb_bus.MEMORY_ARBITER_MemWE_Out), 32'h0);
    check("abort_cpu_ack", 32'(cack_cnt), 32'h0);
    run_until_acks("abort_regrant", 1, 20);
    check("abort_latency", 32'(last_cack_cyc - t1), 32'(WS + 2));
    step();

    // Randomized traffic with occasional resets
    scramble_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (!cpu_pend && $urandom_range(0, 3) == 0) begin
        cpu_kind = $urandom_range(0, 2);
        cpu_addr = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
        cpu_data = $urandom;
        cpu_pend = 1'b1;
      end
      if (!ld_pend && $urandom_range(0, 3) == 0) begin
        ld_we   = 1'($urandom_range(0, 1));
        ld_addr = 12'($urandom_range(0, 15));
        ld_data = $urandom;
        ld_pend = 1'b1;
      end
      rst_drv = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single-port main memory between the microcoded CPU (driven by the control unit's read and write strobes, which expect an ACK) and the external program loader/debug port. It grants one requester at a time, inserts a fixed number of memory wait states, and returns read data. It pulses a one-cycle acknowledge that lets the control unit's address incrementer advance past the memory microinstruction.

## Interface
Parameters:
- DATAWIDTH_BUS, 32, data word width and CPU byte-address width
- DATAWIDTH_MEMADDR, 12, memory word-address width
- WAIT_STATES, 2, extra memory cycles per access (0..15)

Ports:
- MEMORY_ARBITER_CLOCK_50  in  1  system clock, all logic on rising edge
- MEMORY_ARBITER_ResetInHigh_In  in  1  synchronous, active-high reset
- MEMORY_ARBITER_CpuRD_In  in  1  CPU read request (level, held until ack)
- MEMORY_ARBITER_CpuWR_In  in  1  CPU write request (level, held until ack)
- MEMORY_ARBITER_CpuAddress_InBus  in  DATAWIDTH_BUS  CPU byte address
- MEMORY_ARBITER_CpuData_InBus  in  DATAWIDTH_BUS  CPU write data
- MEMORY_ARBITER_CpuAck_Out  out  1  one-cycle CPU completion pulse
- MEMORY_ARBITER_LoaderReq_In  in  1  loader request (level, held until ack)
- MEMORY_ARBITER_LoaderWE_In  in  1  loader 1 = write, 0 = read
- MEMORY_ARBITER_LoaderAddress_InBus  in  DATAWIDTH_MEMADDR  loader word address
- MEMORY_ARBITER_LoaderData_InBus  in  DATAWIDTH_BUS  loader write data
- MEMORY_ARBITER_LoaderAck_Out  out  1  one-cycle loader completion pulse
- MEMORY_ARBITER_ReadData_OutBus  out  DATAWIDTH_BUS  last read data, shared by both requesters
- MEMORY_ARBITER_MemAddress_OutBus  out  DATAWIDTH_MEMADDR  memory word address
- MEMORY_ARBITER_MemData_OutBus  out  DATAWIDTH_BUS  memory write data
- MEMORY_ARBITER_MemRE_Out  out  1  memory read strobe
- MEMORY_ARBITER_MemWE_Out  out  1  memory write strobe
- MEMORY_ARBITER_MemData_InBus  in  DATAWIDTH_BUS  memory read data

## Operation
- Reset is synchronous and active-high. All outputs are registered and reset to 0. State resets to IDLE, the wait counter to 0, and the last-grant flag to LOADER, so the CPU wins the first tie.
- States:
  - IDLE: when any request is present, pick a winner, latch its address, data and direction, then go to ACCESS.
  - ACCESS: drive the memory strobe and address. The wait counter counts from WAIT_STATES down to 0. At 0, latch read data (reads only) and go to DONE.
  - DONE: assert the winner's ack for exactly one cycle, then go to IDLE unconditionally.
- CPU request is RD | WR. If both are asserted, the access is a write (WR wins).
- CPU word address = CpuAddress[DATAWIDTH_MEMADDR+1:2]. Address bits [1:0] are ignored.
- Requests are sampled only in IDLE. A request still asserted during DONE is not re-granted until the following IDLE cycle, so every transaction has at least one IDLE cycle between it and the next.
- Request inputs that change during ACCESS/DONE have no effect, because address, data and direction are latched at grant.
- ReadData holds its value until the next read completes. Writes do not alter it.
- Reset asserted mid-transaction: the transaction is aborted. Strobes are 0 and no ack is issued. The requester must re-request.

## Timing
- The grant decision happens in the IDLE cycle (T0).
- Strobes are high from T1 to T1+WAIT_STATES, inclusive.
- MemData_InBus is sampled at the end of cycle T1+WAIT_STATES.
- Ack and valid ReadData appear at T2+WAIT_STATES. Request-to-ack latency is WAIT_STATES+2 cycles.
- Minimum period between back-to-back transactions is WAIT_STATES+3 cycles.
- Exactly one of MemRE/MemWE is high during ACCESS, and neither is high outside ACCESS.

## Configuration
- Macro MEMORY_ARBITER_ROUND_ROBIN_EN:
  - Defined: when both requesters are present in IDLE, grant the one not granted last. The last-grant flag updates at every grant.
  - Undefined: fixed priority, CPU always wins. Loader requests are served only in IDLE cycles with no CPU request. The last-grant flag is not implemented.

## Structure
- memory_arbiter_pkg holds:
  - state encoding (IDLE, ACCESS, DONE)
  - requester ID constants (REQ_CPU, REQ_LOADER)
  - the wait-counter width, derived from the WAIT_STATES limit of 15
- Sub-module memory_arbiter_grant: combinational/registered winner selection plus the last-grant flag. It is the only place the macro applies.

## Test plan
- WAIT_STATES=2: CPU RD at 0x0000_0010, memory returns 0xDEADBEEF. Expect MemAddress=0x004 and MemRE high for 3 cycles. Expect CpuAck one pulse 4 cycles after the request, with ReadData=0xDEADBEEF.
- CPU RD and WR asserted together, address 0x8, data 0x12345678. Expect MemWE (not MemRE) at word 0x002 with that data. ReadData is unchanged.
- CPU and loader request in the same IDLE cycle, both held:
  - With ROUND_ROBIN_EN: grants alternate CPU, loader, CPU.
  - Without it: CPU is served repeatedly and the loader is starved while the CPU holds its request.
- Loader writes 0xA5A5A5A5 to word 0x7FF, then reads 0x7FF back. Expect LoaderAck twice and ReadData=0xA5A5A5A5. CpuAck stays 0 throughout.
- Reset asserted in the second ACCESS cycle. Expect all strobes and acks at 0 on the next edge and no ack afterward. A request held after reset release is granted from IDLE with full latency.
